// File: rtl/fetch_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_unit_pkg: shared constants, state encoding and buffer entry type      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
// +----------------------------------------------------------------------------+
// | fetch_fifo: instruction buffer with push/pop/clear, combinational head      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_ptr_one = 1;
  localparam logic [AW:0]   c_cnt_one = 1;
  localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_depth);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  // A pop frees the head slot in the same edge, so push at full is fine then
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_cnt_one;
      else if (!w_do_push && w_do_pop) r_count <= r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clear && full && !pop));

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | fetch_unit: IF stage - PC, credit-limited imem requests, redirect flushing  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_error,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic        id_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] c_one   = 1;
  localparam logic [CW:0]   c_depth = (CW+1)'(FIFO_DEPTH);

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [1:0]    w_state_next;
  logic [CW-1:0] w_drop_next;
  logic [CW-1:0] w_out_after_rsp;
  logic [CW-1:0] w_outstanding_next;
  logic [CW:0]   w_credit_used;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_req_fire;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_unused_bits;

  assign w_unused_bits = ^{redirect_pc[1:0], w_fifo_full};
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req_valid = (r_state != ST_BOOT) && !redirect_valid && (w_credit_used < c_depth);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response in the redirect cycle belongs to the abandoned stream
  assign w_drop = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
  assign w_push = imem_rsp_valid && !w_drop;
  assign w_pop  = !w_fifo_empty && !id_stall && !redirect_valid;

  assign w_out_after_rsp    = r_outstanding - (imem_rsp_valid ? c_one : '0);
  assign w_outstanding_next = w_out_after_rsp + (w_req_fire ? c_one : '0);

  assign w_push_entry.pc    = r_rsp_pc;
  assign w_push_entry.instr = imem_rsp_error ? NOP_INSTR : imem_rsp_data;
  assign w_push_entry.fault = imem_rsp_error;

  always_comb begin
    w_drop_next = r_drop_cnt;
    if (redirect_valid)
      w_drop_next = w_out_after_rsp;
    else if (imem_rsp_valid && (r_drop_cnt != '0))
      w_drop_next = r_drop_cnt - c_one;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_BOOT)      w_state_next = ST_RUN;
    else if (w_drop_next != '0)  w_state_next = ST_FLUSH;
    else                         w_state_next = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      r_drop_cnt    <= w_drop_next;
      if (redirect_valid) begin
        r_pc     <= w_redirect_pc;
        r_rsp_pc <= w_redirect_pc;
      end else begin
        if (w_req_fire) r_pc     <= r_pc + 32'd4;
        if (w_push)     r_rsp_pc <= r_rsp_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .clear     (redirect_valid),
    .push_data (w_push_entry),
    .head      (w_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign id_valid       = !w_fifo_empty;
  assign id_instruction = w_fifo_empty ? NOP_INSTR : w_head.instr;
  assign id_pc          = w_fifo_empty ? 32'h0 : w_head.pc;
  assign id_fault       = !w_fifo_empty && w_head.fault;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch (IF) stage that sits directly upstream of the instruction decoder. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready handshake. In-order responses go into a small FIFO, which presents {instruction, pc, fault} to the decoder. It handles branch/jump/trap redirects from later stages by flushing the FIFO and discarding responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries (power of 2, ≥2)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; responses return in order, at least 1 cycle after acceptance
imem_rsp_data  in  32  fetched instruction word
imem_rsp_error  in  1  access fault for this response
redirect_valid  in  1  branch/jump/trap taken; highest priority
redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0)
id_stall  in  1  decoder cannot accept this cycle
id_valid  out  1  id_instruction/id_pc/id_fault are valid
id_instruction  out  32  instruction to decoder; 32'h0000_0013 (NOP) when !id_valid
id_pc  out  32  PC of id_instruction
id_fault  out  1  instruction fetch access fault

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=BOOT.
- Outputs during reset: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_instruction=NOP, id_pc=0, id_fault=0.
- States:
  - BOOT: exactly one cycle after rst_n deasserts → RUN.
  - RUN: normal fetching.
  - FLUSH: drop_cnt>0; stale responses are discarded. → RUN when drop_cnt reaches 0, or on the same cycle the last stale response arrives.
- Request issue: imem_req_valid = (state!=BOOT) && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
  - imem_req_addr = pc.
  - On handshake: pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC → 0); outstanding++.
  - Requests continue during FLUSH at the new pc. Stale slots are counted in outstanding, so credits stay correct.
- Response handling:
  - If drop_cnt>0, the response is dropped: drop_cnt--, outstanding--.
  - Otherwise it is pushed: {pc_of_request, data, error}; outstanding--.
  - Request PCs are tracked in an in-order tag FIFO, or recomputed as (head pc + 4·k); choose one, not both.
- Credit rule guarantees no push to a full FIFO. A push to a full FIFO is a design bug; an assertion flags it.
- Decoder output: id_valid = FIFO non-empty; head fields drive the outputs combinationally. Pop when id_valid && !id_stall.
  - A push into an empty FIFO becomes visible the next cycle (no bypass).
  - Simultaneous push and pop is legal at any occupancy.
- Redirect (redirect_valid=1 in cycle T):
  - FIFO cleared at the edge ending T; no pop of head occurs in T.
  - drop_cnt <= outstanding after T's response (a response arriving in T is dropped too).
  - pc <= {redirect_pc[31:2],2'b00}.
  - No request issued in T. id_valid=0 in T+1.
  - Fastest refill: request in T+1, response in T+2, id_valid in T+3.
  - Redirect during FLUSH re-arms drop_cnt the same way; the count is cumulative and correct.
  - Redirect overrides everything else in the same cycle.
- Faulted fetch is delivered as a normal entry with id_fault=1 and id_instruction=NOP. Fetching continues; the trap arrives later as a redirect.
- id_stall has no effect on request issue except via credits. A fully stalled decoder stops fetching once fifo_count + outstanding = FIFO_DEPTH.
- Counter widths: outstanding and drop_cnt are clog2(FIFO_DEPTH)+1 bits; neither ever underflows.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h0000_0013
  - default RESET_PC
  - fetch state encoding {BOOT, RUN, FLUSH}
  - fetch-entry typedef {pc[31:0], instr[31:0], fault}
- One sub-module, fetch_fifo:
  - parameterised depth
  - push/pop/clear
  - count, full/empty
  - async active-low reset
  - registered storage, combinational head read

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory latency → requests at 0x0,0x4,0x8...; id_valid first high 3 cycles after rst_n rises, with id_pc=0x0 then 0x4, one instruction per cycle.
- id_stall=1 held 10 cycles with fast memory → at most 2 requests beyond the last pop; FIFO holds exactly 2 entries; id_pc stays constant; no overflow assertion fires.
- Redirect to 0x1002 while 2 requests are outstanding → both stale responses dropped; next request addr=0x1000; first id_valid entry has id_pc=0x1000.
- Redirect coincident with an arriving response and with id_valid&&!id_stall → response and head both discarded; id_valid=0 next cycle; no spurious pop.
- imem_rsp_error=1 for the fetch at 0x8 → entry delivered with id_pc=0x8, id_fault=1, id_instruction=0x0000_0013; following 0xC fetched normally.
- rst_n asserted mid-FLUSH with drop_cnt=2 → all outputs immediately at reset values; after release, fetch restarts at RESET_PC; late responses from before reset are ignored by the bench memory model.
